function_stack: RTL and testbench

- Return-address stack for the stack-machine core; sits directly upstream of the PC/instruction fetch block.
- Its top-of-stack output drives that block's function_stack mux input (SEL_MUX = 2'b11).
- CALL pushes the return address, computed from the current PC plus the instruction length. RETURN pops it in the same cycle the PC loads it.
- Holds the cached top entry in a register, so the PC mux sees it with zero combinational depth.

---
 rtl/function_stack.sv | 118 +++++++++++
 tb/tb_function_stack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/function_stack.sv
// Return-address stack for the stack-machine core, with a registered top-of-stack output for the fetch mux.
// Optional high-water-mark output HWM_OUT is enabled by defining FUNCTION_STACK_HWM_EN.
module function_stack #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 16,
   parameter int PTR_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] PC_IN,
   input  logic                  CTRL_PUSH,
   input  logic                  CTRL_POP,
   input  logic                  SEL_RET_OFFSET,
   output logic [ADDR_WIDTH-1:0] TOS_OUT,
   output logic [PTR_WIDTH:0]    DEPTH_OUT,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  OVERFLOW_ERR,
   output logic                  UNDERFLOW_ERR
`ifdef FUNCTION_STACK_HWM_EN
   ,
   output logic [PTR_WIDTH:0]    HWM_OUT
`endif
);

   localparam logic [PTR_WIDTH:0] ONE      = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0] TWO      = (PTR_WIDTH+1)'(2);
   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
   logic [PTR_WIDTH:0]    depth_q, depth_d;
   logic [ADDR_WIDTH-1:0] tos_q, tos_d, ret_addr;
   logic                  ovf_q, unf_q, ovf_set, unf_set, wr_en;
   logic [PTR_WIDTH-1:0]  wr_idx, push_idx, top_idx, below_idx;
   logic                  is_empty, is_full, is_one;

   assign ret_addr  = PC_IN + (SEL_RET_OFFSET ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
   assign is_empty  = (depth_q == '0);
   assign is_full   = (depth_q == FULL_CNT);
   assign is_one    = (depth_q == ONE);
   assign push_idx  = PTR_WIDTH'(depth_q);
   assign top_idx   = PTR_WIDTH'(depth_q - ONE);
   assign below_idx = PTR_WIDTH'(depth_q - TWO);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      depth_d = depth_q;
      tos_d   = tos_q;
      wr_en   = 1'b0;
      wr_idx  = push_idx;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (CTRL_PUSH && CTRL_POP && !is_empty) begin
         // Tail call: overwrite the top in place, depth unchanged.
         wr_en  = 1'b1;
         wr_idx = top_idx;
         tos_d  = ret_addr;
      end else if (CTRL_PUSH) begin
         if (is_full) begin
            ovf_set = 1'b1;
         end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + ONE;
            tos_d   = ret_addr;
         end
      end else if (CTRL_POP) begin
         if (is_empty) begin
            unf_set = 1'b1;
         end else if (is_one) begin
            depth_d = '0;
            tos_d   = '0;
         end else begin
            depth_d = depth_q - ONE;
            tos_d   = mem[below_idx];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
         tos_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_d;
         tos_q   <= tos_d;
         if (ovf_set) ovf_q <= 1'b1;
         if (unf_set) unf_q <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; entries above the depth are never observed.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_idx] <= ret_addr;
   end

   assign TOS_OUT       = tos_q;
   assign DEPTH_OUT     = depth_q;
   assign EMPTY         = is_empty;
   assign FULL          = is_full;
   assign OVERFLOW_ERR  = ovf_q;
   assign UNDERFLOW_ERR = unf_q;

`ifdef FUNCTION_STACK_HWM_EN
   logic [PTR_WIDTH:0] hwm_q;

   // Follows DEPTH_OUT one cycle late; rejected pushes never move the depth.
   always_ff @(posedge clk) begin
      if (reset)                hwm_q <= '0;
      else if (depth_q > hwm_q) hwm_q <= depth_q;
   end

   assign HWM_OUT = hwm_q;
`endif

endmodule

// File: tb/tb_function_stack.sv
// Self-checking bench for function_stack: queue-based reference model compared every cycle, plus literal checks.
// Define FUNCTION_STACK_HWM_EN to also exercise HWM_OUT.
module tb_function_stack;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] PC_IN = '0;
   logic        CTRL_PUSH = 1'b0;
   logic        CTRL_POP = 1'b0;
   logic        SEL_RET_OFFSET = 1'b0;
   logic [11:0] TOS_OUT;
   logic [4:0]  DEPTH_OUT;
   logic        EMPTY, FULL, OVERFLOW_ERR, UNDERFLOW_ERR;
`ifdef FUNCTION_STACK_HWM_EN
   logic [4:0]  HWM_OUT;
`endif

   function_stack #(.ADDR_WIDTH(12), .STACK_DEPTH(16), .PTR_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .PC_IN(PC_IN), .CTRL_PUSH(CTRL_PUSH), .CTRL_POP(CTRL_POP),
      .SEL_RET_OFFSET(SEL_RET_OFFSET), .TOS_OUT(TOS_OUT), .DEPTH_OUT(DEPTH_OUT), .EMPTY(EMPTY),
      .FULL(FULL), .OVERFLOW_ERR(OVERFLOW_ERR), .UNDERFLOW_ERR(UNDERFLOW_ERR)
`ifdef FUNCTION_STACK_HWM_EN
      , .HWM_OUT(HWM_OUT)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference model: a queue of return addresses and sticky flags.
   logic [11:0] m_q[$];
   bit          m_ovf = 1'b0, m_unf = 1'b0;
   int          m_hwm = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] m_tos();
      return (m_q.size() == 0) ? 12'h000 : m_q[m_q.size()-1];
   endfunction

   task automatic model_step();
      logic [11:0] ra;
      if (reset) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_hwm = 0;
      end else begin
         if (m_q.size() > m_hwm) m_hwm = m_q.size();
         ra = PC_IN + (SEL_RET_OFFSET ? 12'd2 : 12'd1);
         if (CTRL_PUSH && CTRL_POP && m_q.size() > 0) m_q[m_q.size()-1] = ra;
         else if (CTRL_PUSH) begin
            if (m_q.size() < 16) m_q.push_back(ra);
            else                 m_ovf = 1'b1;
         end else if (CTRL_POP) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else                 void'(m_q.pop_back());
         end
      end
   endtask

   // One clock cycle: drive inputs, advance the model on the edge, settle.
   task automatic cyc(input bit rst, input bit push, input bit pop, input bit sel, input logic [11:0] pc);
      reset = rst;
      CTRL_PUSH = push;
      CTRL_POP = pop;
      SEL_RET_OFFSET = sel;
      PC_IN = pc;
      @(posedge clk);
      model_step();
      #1;
      chk_en = 1'b1;
   endtask

   // Compare process: every cycle after the first reset edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("tos", 32'(TOS_OUT), 32'(m_tos()));
         check("depth", 32'(DEPTH_OUT), 32'(m_q.size()));
         check("empty", 32'(EMPTY), 32'(m_q.size() == 0));
         check("full", 32'(FULL), 32'(m_q.size() == 16));
         check("ovf", 32'(OVERFLOW_ERR), 32'(m_ovf));
         check("unf", 32'(UNDERFLOW_ERR), 32'(m_unf));
`ifdef FUNCTION_STACK_HWM_EN
         check("hwm", 32'(HWM_OUT), 32'(m_hwm));
`endif
      end
   end

   initial begin
      // Reset, then idle.
      cyc(1, 0, 0, 0, 12'h000);
      cyc(1, 0, 0, 0, 12'h000);
      repeat (3) cyc(0, 0, 0, 0, 12'h000);
      check("rst_tos", 32'(TOS_OUT), 32'h000);
      check("rst_depth", 32'(DEPTH_OUT), 32'd0);
      check("rst_empty", 32'(EMPTY), 32'd1);
      check("rst_full", 32'(FULL), 32'd0);
      check("rst_ovf", 32'(OVERFLOW_ERR), 32'd0);
      check("rst_unf", 32'(UNDERFLOW_ERR), 32'd0);

      // Basic push/pop with both offsets.
      cyc(0, 1, 0, 0, 12'h100);
      check("push1_tos", 32'(TOS_OUT), 32'h101);
      cyc(0, 1, 0, 1, 12'h205);
      check("push2_tos", 32'(TOS_OUT), 32'h207);
      check("push2_depth", 32'(DEPTH_OUT), 32'd2);
      cyc(0, 0, 1, 0, 12'h000);
      check("pop1_tos", 32'(TOS_OUT), 32'h101);
      check("pop1_depth", 32'(DEPTH_OUT), 32'd1);
      cyc(0, 0, 1, 0, 12'h000);
      check("pop2_tos", 32'(TOS_OUT), 32'h000);
      check("pop2_empty", 32'(EMPTY), 32'd1);

      // Address wrap.
      cyc(0, 1, 0, 1, 12'hFFF);
      check("wrap_tos", 32'(TOS_OUT), 32'h001);
      cyc(0, 0, 1, 0, 12'h000);

      // Fill, overflow, drain.
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 12'(i));
      check("fill_full", 32'(FULL), 32'd1);
      check("fill_tos", 32'(TOS_OUT), 32'h010);
      cyc(0, 1, 0, 0, 12'h3AA);
      check("ovf_flag", 32'(OVERFLOW_ERR), 32'd1);
      check("ovf_tos", 32'(TOS_OUT), 32'h010);
      check("ovf_depth", 32'(DEPTH_OUT), 32'd16);
      for (int k = 0; k < 16; k++) begin
         check("drain_tos", 32'(TOS_OUT), 32'(16 - k));
         cyc(0, 0, 1, 0, 12'h000);
      end
      check("drain_empty", 32'(EMPTY), 32'd1);
      check("drain_ovf_sticky", 32'(OVERFLOW_ERR), 32'd1);

      // Tail call, underflow, push+pop on empty, reset clears flags.
      cyc(1, 0, 0, 0, 12'h000);
      cyc(0, 1, 0, 0, 12'h030);
      cyc(0, 1, 0, 0, 12'h040);
      cyc(0, 1, 0, 0, 12'h04F);
      check("d3_tos", 32'(TOS_OUT), 32'h050);
      cyc(0, 1, 1, 0, 12'h080);
      check("tail_tos", 32'(TOS_OUT), 32'h081);
      check("tail_depth", 32'(DEPTH_OUT), 32'd3);
      cyc(0, 0, 1, 0, 12'h000);
      check("tail_pop_tos", 32'(TOS_OUT), 32'h041);
      cyc(0, 0, 1, 0, 12'h000);
      cyc(0, 0, 1, 0, 12'h000);
      check("underflow_pre", 32'(UNDERFLOW_ERR), 32'd0);
      cyc(0, 0, 1, 0, 12'h000);
      check("underflow_flag", 32'(UNDERFLOW_ERR), 32'd1);
      cyc(0, 1, 1, 0, 12'h010);
      check("pp_empty_tos", 32'(TOS_OUT), 32'h011);
      check("pp_empty_depth", 32'(DEPTH_OUT), 32'd1);
      cyc(1, 0, 0, 0, 12'h000);
      check("rst2_ovf", 32'(OVERFLOW_ERR), 32'd0);
      check("rst2_unf", 32'(UNDERFLOW_ERR), 32'd0);
      check("rst2_depth", 32'(DEPTH_OUT), 32'd0);

      // Push 5, pop 3, push 1.
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 12'(16'h200 + i));
      repeat (3) cyc(0, 0, 1, 0, 12'h000);
      cyc(0, 1, 0, 1, 12'h300);
      cyc(0, 0, 0, 0, 12'h000);
      check("hwm_seq_depth", 32'(DEPTH_OUT), 32'd3);
      check("hwm_seq_tos", 32'(TOS_OUT), 32'h302);
`ifdef FUNCTION_STACK_HWM_EN
      check("hwm_value", 32'(HWM_OUT), 32'd5);
`endif

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
